// File: rtl/common.sv
// Shared types for the memory stage: FSM states, load/store funct3 codes,
// and the pipeline control/decode records exchanged with neighbouring stages.
package common;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} MemState;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       enable;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
  } DecodeInfo;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } PipeRequest;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: load extraction/extension, store byte
// enables and lane-replicated store data. Purely combinational.
module lsu_align
  import common::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        mem_write_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{off_i, 3'b000} +: 8];
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'h0, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'h0, half_v};
      F3_W:    load_o = rdata_i;
      default: load_o = 32'h0;
    endcase

    // Misaligned halfwords are not trapped; lane choice comes from bit 1 only.
    if (!mem_write_i) begin
      be_o = 4'b1111;
    end else begin
      case (funct3_i)
        F3_B:    be_o = 4'b0001 << off_i;
        F3_H:    be_o = off_i[1] ? 4'b1100 : 4'b0011;
        F3_W:    be_o = 4'b1111;
        default: be_o = 4'b0000;
      endcase
    end

    case (funct3_i)
      F3_B:    wdata_o = {4{store_data_i[7:0]}};
      F3_H:    wdata_o = {2{store_data_i[15:0]}};
      default: wdata_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage: drives the data bus, stalls until ack, and registers
// the stage result. DONE parks a completed access while the pipe is held.
module memory
  import common::*;
(
  input  logic        clk,
  input  logic        rst,
  output PipeRequest  req,
  input  PipeControl  pipe,
  input  DecodeInfo   info,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] mem_out,
  output DecodeInfo   info_ff
);

  MemState     state_q, state_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic [31:0] mem_out_q, mem_out_d;
  DecodeInfo   info_q, info_d;

  logic        memop, active, ack;
  logic [31:0] rdata_sel, load_v, result;

  lsu_align u_align (
    .funct3_i     (info.funct3),
    .off_i        (alu_out[1:0]),
    .mem_write_i  (info.mem_write),
    .rdata_i      (rdata_sel),
    .store_data_i (store_data),
    .load_o       (load_v),
    .be_o         (dbus_be),
    .wdata_o      (dbus_wdata)
  );

  always_comb begin
    memop  = info.enable && (info.mem_read || info.mem_write);
    active = memop && (state_q != DONE);
    ack    = active && dbus_ack;

    dbus_req  = active && !rst;
    dbus_we   = info.mem_write;
    dbus_addr = {alu_out[31:2], 2'b00};

    req           = '0;
    req.stall_req = active && !dbus_ack;
    req.flush_req = 4'b0000;

    state_d = state_q;
    case (state_q)
      IDLE, WAIT: begin
        if (ack)        state_d = pipe.stall ? DONE : IDLE;
        else if (memop) state_d = WAIT;
        else            state_d = IDLE;
      end
      DONE:    if (!pipe.stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Once parked in DONE the bus data is gone; replay it from the hold register.
    rdata_hold_d = ack ? dbus_rdata : rdata_hold_q;
    rdata_sel    = ack ? dbus_rdata : rdata_hold_q;

    result = !info.enable ? 32'h0 : info.mem_read ? load_v : alu_out;

    mem_out_d = mem_out_q;
    info_d    = info_q;
    if (!pipe.stall) begin
      mem_out_d = pipe.flush ? 32'h0 : result;
      info_d    = pipe.flush ? '0 : info;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rdata_hold_q <= 32'h0;
      mem_out_q    <= 32'h0;
      info_q       <= '0;
    end else begin
      state_q      <= state_d;
      rdata_hold_q <= rdata_hold_d;
      mem_out_q    <= mem_out_d;
      info_q       <= info_d;
    end
  end

  assign mem_out = mem_out_q;
  assign info_ff = info_q;

endmodule

// File: tb/tb_memory.sv
// Bench for the memory stage: directed scenarios plus a randomized run
// against a byte-lane reference model; the pipeline controller is modelled.
module tb_memory;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  PipeRequest  req;
  PipeControl  pipe;
  DecodeInfo   info;
  logic [31:0] alu_out, store_data, dbus_addr, dbus_wdata, dbus_rdata, mem_out;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [3:0]  dbus_be;
  DecodeInfo   info_ff;
  logic        ext_stall, ext_flush;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Controller: stall whenever this stage asks, or an outside hazard holds the pipe.
  assign pipe = {req.stall_req | ext_stall, ext_flush};

  memory dut (
    .clk(clk), .rst(rst), .req(req), .pipe(pipe), .info(info),
    .alu_out(alu_out), .store_data(store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .mem_out(mem_out), .info_ff(info_ff)
  );

  function automatic DecodeInfo mk(bit en, bit rd, bit wr, logic [2:0] f3, logic [4:0] r);
    DecodeInfo d;
    d = '0;
    d.enable = en; d.mem_read = rd; d.mem_write = wr; d.funct3 = f3; d.rd = r;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] a, bit wr);
    if (!wr) return 4'hF;
    case (f3)
      3'd0:    return 4'(1 << a[1:0]);
      3'd1:    return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] sd);
    case (f3)
      3'd0:    return (sd & 32'hFF) * 32'h0101_0101;
      3'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    info = '0; dbus_ack = 0; ext_stall = 0; ext_flush = 0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1; info = mk(1, 1, 0, F3_W, 5'd3); alu_out = 32'h40; dbus_ack = 0;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dbus_req); end
    cyc(); cyc();
    checks++;
    if (mem_out !== 32'h0) begin failures++; $display("FAIL reset_mem_out got=%h exp=0", mem_out); end
    checks++;
    if (info_ff !== DecodeInfo'(0)) begin failures++; $display("FAIL reset_info_ff got=%h exp=0", info_ff); end
    checks++;
    if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
    rst = 0; info = '0;
    cyc();
  endtask

  task automatic test_lw();
    DecodeInfo d;
    d = mk(1, 1, 0, F3_W, 5'd7);
    info = d; alu_out = 32'h100; dbus_ack = 1; dbus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h100 || req.stall_req !== 1'b0 || dbus_we !== 1'b0) begin
      failures++; $display("FAIL lw_bus got req=%b addr=%h stall=%b we=%b exp 1/100/0/0", dbus_req, dbus_addr, req.stall_req, dbus_we);
    end
    cyc();
    checks++;
    if (mem_out !== 32'hDEADBEEF || info_ff !== d) begin
      failures++; $display("FAIL lw_result got=%h info=%h exp=deadbeef info=%h", mem_out, info_ff, d);
    end
    idle();
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [3] = '{3'd0, 3'd4, 3'd5};
    logic [31:0] ad [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] ex [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    for (int i = 0; i < 3; i++) begin
      info = mk(1, 1, 0, f3[i], 5'd1); alu_out = ad[i]; dbus_ack = 1; dbus_rdata = 32'h80FF_FF7F;
      cyc();
      checks++;
      if (mem_out !== ex[i]) begin failures++; $display("FAIL load_ext%0d got=%h exp=%h", i, mem_out, ex[i]); end
    end
    idle();
  endtask

  task automatic test_sh();
    info = mk(1, 0, 1, F3_H, 5'd0); alu_out = 32'h206; store_data = 32'h1234ABCD; dbus_ack = 1;
    @(negedge clk);
    checks++;
    if (dbus_be !== 4'b1100 || dbus_wdata !== 32'hABCDABCD || dbus_we !== 1'b1) begin
      failures++; $display("FAIL sh_bus got be=%b wdata=%h we=%b exp 1100/abcdabcd/1", dbus_be, dbus_wdata, dbus_we);
    end
    cyc();
    checks++;
    if (mem_out !== 32'h206) begin failures++; $display("FAIL sh_result got=%h exp=206", mem_out); end
    idle();
  endtask

  task automatic test_sw_wait();
    int nreq = 0, nstall = 0, nack = 0;
    logic [31:0] a;
    a = {$urandom_range(1, 32'hFFFF), 2'b00};
    info = mk(1, 0, 1, F3_W, 5'd0); alu_out = a; store_data = $urandom;
    for (int k = 0; k < 4; k++) begin
      dbus_ack = (k == 3);
      @(negedge clk);
      if (dbus_req) nreq++;
      if (req.stall_req) nstall++;
      if (dbus_req && dbus_ack) nack++;
      cyc();
    end
    checks++;
    if (nreq != 4 || nstall != 3 || nack != 1) begin
      failures++; $display("FAIL sw_wait got req=%0d stall=%0d ack=%0d exp 4/3/1", nreq, nstall, nack);
    end
    checks++;
    if (mem_out !== a) begin failures++; $display("FAIL sw_wait_result got=%h exp=%h", mem_out, a); end
    info = '0; dbus_ack = 0;
  endtask

  task automatic test_flush_wait();
    int nreq = 0;
    logic [31:0] held;
    held = mem_out;
    info = mk(1, 1, 0, F3_W, 5'd2); alu_out = 32'h80; ext_flush = 1; dbus_rdata = 32'h5555AAAA;
    for (int k = 0; k < 3; k++) begin
      dbus_ack = (k == 2);
      @(negedge clk);
      if (dbus_req) nreq++;
      cyc();
      if (k < 2) begin
        checks++;
        if (mem_out !== held) begin failures++; $display("FAIL flush_hold%0d got=%h exp=%h", k, mem_out, held); end
      end
    end
    checks++;
    if (nreq != 3 || mem_out !== 32'h0) begin
      failures++; $display("FAIL flush_wait got req=%0d mem_out=%h exp 3/0", nreq, mem_out);
    end
    idle();
  endtask

  task automatic test_sb_done();
    int nreq = 0;
    info = mk(1, 0, 1, F3_B, 5'd0); alu_out = 32'h101; store_data = 32'hA5; dbus_ack = 1; ext_stall = 1;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b1 || dbus_be !== 4'b0010 || dbus_wdata !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL sb_bus got req=%b be=%b wdata=%h exp 1/0010/a5a5a5a5", dbus_req, dbus_be, dbus_wdata);
    end
    cyc();
    dbus_ack = 0;
    for (int k = 0; k < 3; k++) begin
      ext_stall = (k < 2);
      @(negedge clk);
      if (dbus_req) nreq++;
      checks++;
      if (dut.state_q !== DONE || req.stall_req !== 1'b0) begin
        failures++; $display("FAIL sb_done%0d got state=%0d stall=%b exp DONE/0", k, dut.state_q, req.stall_req);
      end
      cyc();
      checks++;
      if (mem_out !== ((k < 2) ? 32'h0 : 32'h101)) begin
        failures++; $display("FAIL sb_out%0d got=%h exp=%h", k, mem_out, (k < 2) ? 32'h0 : 32'h101);
      end
    end
    checks++;
    if (nreq != 0) begin failures++; $display("FAIL sb_rewrite got=%0d exp=0", nreq); end
    idle();
  endtask

  task automatic test_rst_wait();
    info = mk(1, 1, 0, F3_W, 5'd9); alu_out = 32'h44; dbus_ack = 1; dbus_rdata = 32'h1234_5678;
    cyc();
    dbus_ack = 0;
    cyc();
    rst = 1;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b0) begin failures++; $display("FAIL rst_wait_req got=%b exp=0", dbus_req); end
    cyc();
    rst = 0;
    checks++;
    if (mem_out !== 32'h0 || info_ff !== DecodeInfo'(0) || dut.state_q !== IDLE) begin
      failures++; $display("FAIL rst_wait_state got mem=%h info=%h st=%0d exp 0/0/IDLE", mem_out, info_ff, dut.state_q);
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] prev, exp, a, sd, rdv;
    DecodeInfo   d;
    int kind, waits, xst;
    bit memop;
    idle();
    prev = 32'h0;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      a = $urandom; sd = $urandom; rdv = $urandom;
      case (kind)
        0, 1, 2, 3: d = mk(1, 1, 0, 3'($urandom_range(0, 7)), 5'($urandom));
        4, 5:       d = mk(1, 0, 1, 3'($urandom_range(0, 2)), 5'($urandom));
        6:          d = mk(1, 0, 0, 3'($urandom), 5'($urandom));
        default:    d = mk(0, $urandom_range(0, 1), 0, 3'($urandom), 5'($urandom));
      endcase
      memop = d.enable && (d.mem_read || d.mem_write);
      waits = memop ? $urandom_range(0, 3) : 0;
      xst   = memop ? $urandom_range(0, 2) : 0;
      exp = !d.enable ? 32'h0 : d.mem_read ? ref_load(d.funct3, a, rdv) : a;
      info = d; alu_out = a; store_data = sd;
      for (int k = 0; k <= waits; k++) begin
        dbus_ack   = memop && (k == waits);
        dbus_rdata = (k == waits) ? rdv : $urandom;
        ext_stall  = (k == waits) && (xst > 0);
        @(negedge clk);
        checks++;
        if (dbus_req !== memop || req.stall_req !== (memop && k < waits)) begin
          failures++; $display("FAIL rnd%0d_ctl got req=%b stall=%b exp %b/%b", n, dbus_req, req.stall_req, memop, memop && k < waits);
        end
        if (memop) begin
          checks++;
          if (dbus_addr !== (a & ~32'h3) || dbus_we !== d.mem_write || dbus_be !== ref_be(d.funct3, a, d.mem_write)
              || (d.mem_write && dbus_wdata !== ref_wdata(d.funct3, sd))) begin
            failures++; $display("FAIL rnd%0d_bus got addr=%h we=%b be=%b wd=%h exp %h/%b/%b/%h", n, dbus_addr, dbus_we,
                                 dbus_be, dbus_wdata, a & ~32'h3, d.mem_write, ref_be(d.funct3, a, d.mem_write), ref_wdata(d.funct3, sd));
          end
        end
        cyc();
        if (k < waits || xst > 0) begin
          checks++;
          if (mem_out !== prev) begin failures++; $display("FAIL rnd%0d_hold got=%h exp=%h", n, mem_out, prev); end
        end
      end
      dbus_ack = 0;
      for (int j = 0; j < xst; j++) begin
        ext_stall = (j < xst - 1);
        dbus_rdata = $urandom;
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b0) begin failures++; $display("FAIL rnd%0d_done_req got=%b exp=0", n, dbus_req); end
        cyc();
      end
      checks++;
      if (mem_out !== exp || info_ff !== d) begin
        failures++; $display("FAIL rnd%0d_out got=%h info=%h exp=%h info=%h", n, mem_out, info_ff, exp, d);
      end
      prev = exp;
      ext_stall = 0;
    end
    idle();
  endtask

  initial begin
    rst = 1; info = '0; alu_out = '0; store_data = '0; dbus_ack = 0; dbus_rdata = '0;
    ext_stall = 0; ext_flush = 0;
    #1;
    test_reset();
    test_lw();
    test_load_ext();
    test_sh();
    test_sw_wait();
    test_flush_wait();
    test_sb_done();
    test_rst_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have the following ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  out  PipeRequest  stall and flush requests to the pipeline controller.
- pipe  in  PipeControl  stall and flush commands for this stage.
- info  in  DecodeInfo  instruction from the execute-stage register.
- alu_out  in  32  execute result; the effective address for loads and stores.
- store_data  in  32  forwarded rs2 value of the instruction in info.
- dbus_req  out  1  data-bus request.
- dbus_we  out  1  1 = store, 0 = load.
- dbus_addr  out  32  word address {alu_out[31:2], 2'b00}.
- dbus_wdata  out  32  lane-replicated store data.
- dbus_be  out  4  byte enables.
- dbus_ack  in  1  access complete; dbus_rdata is valid in the same cycle.
- dbus_rdata  in  32  load data.
- mem_out  out  32  registered stage result.
- info_ff  out  DecodeInfo  registered copy of info.

Function
REQ-002 A memory operation (memop) SHALL be defined as info.enable && (info.mem_read || info.mem_write).
REQ-003 The FSM SHALL have three states: IDLE, WAIT and DONE.
- IDLE to WAIT: memop && !dbus_ack.
- IDLE or WAIT to DONE: dbus_ack && pipe.stall.
- IDLE or WAIT to IDLE: dbus_ack && !pipe.stall.
- DONE to IDLE: !pipe.stall.
REQ-004 dbus_req SHALL equal memop in IDLE or WAIT, and SHALL be 0 in DONE and whenever rst=1.
REQ-005 dbus_req, dbus_addr, dbus_we, dbus_be and dbus_wdata SHALL be held stable until dbus_ack; zero-wait (ack in the same cycle as req) SHALL be supported.
REQ-006 req.stall_req SHALL equal memop && state!=DONE && !dbus_ack.
REQ-007 req.flush_req SHALL be 4'b0000.
REQ-008 In DONE, no new bus access SHALL be issued, so a stalled store is never written twice.
REQ-009 On ack, load data SHALL be latched into rdata_hold; the load result SHALL use dbus_rdata when ack=1, otherwise rdata_hold (in DONE).
REQ-010 Load extraction SHALL use off=alu_out[1:0]:
- LB (funct3 000) / LBU (100): byte at lane off, sign- or zero-extended.
- LH (001) / LHU (101): halfword at lane alu_out[1], sign- or zero-extended.
- LW (010): the full word.
- Any other funct3: 0.
REQ-011 Stores SHALL drive byte enables and data as follows:
- SB: be = 4'b0001<<off, wdata = {4{store_data[7:0]}}.
- SH: be = alu_out[1] ? 4'b1100 : 4'b0011, wdata = {2{store_data[15:0]}}.
- SW: be = 4'b1111, wdata = store_data.
- Loads: be = 4'b1111.
REQ-012 Misaligned accesses SHALL NOT trap; the lane selection of REQ-010/011 SHALL apply as-is.
REQ-013 Output register priority SHALL be rst > pipe.stall (hold) > pipe.flush (clear to 0) > load.
REQ-014 On load, mem_out SHALL take !info.enable ? 0 : info.mem_read ? load result : alu_out.
REQ-015 On load, info_ff SHALL take info.
REQ-016 Latency SHALL be one cycle from info to mem_out with ack in the same cycle, plus one cycle per wait cycle.
REQ-017 pipe.flush while in WAIT SHALL NOT abort the bus access (stall has priority); the access SHALL complete before the clear takes effect.

Reset
REQ-018 When rst=1, at the next edge: state=IDLE, mem_out=0, info_ff=0, rdata_hold=0.
REQ-019 rst asserted mid-access SHALL abandon the access, with dbus_req=0 in the same cycle.

Structure
REQ-020 The shared package common.sv SHALL hold:
- the MemState enum (IDLE, WAIT, DONE);
- the load/store funct3 constants;
- the DecodeInfo fields mem_read and mem_write.
REQ-021 A combinational sub-module lsu_align SHALL implement the load extraction, byte enables and store-data replication.
REQ-022 memory SHALL contain only the FSM, the stall logic and the registers.

Verification
REQ-023 LW, alu_out=0x100, ack in the same cycle, rdata=0xDEADBEEF -> dbus_addr=0x100, stall_req=0, next-cycle mem_out=0xDEADBEEF.
REQ-024 LB, alu_out=0x103, rdata=0x80FF_FF7F -> mem_out=0xFFFFFF80; LBU -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-025 SH, alu_out=0x206, store_data=0x1234ABCD -> be=4'b1100, wdata=0xABCDABCD, mem_out=0x206.
REQ-026 SW with ack delayed 3 cycles -> stall_req high for 3 cycles, dbus_req high for 4 cycles, exactly one ack consumed.
REQ-027 SB with ack while an external pipe.stall is held 2 more cycles -> FSM in DONE, dbus_req=0, no second write, mem_out loads after the stall drops.
REQ-028 rst during WAIT -> dbus_req=0 in that cycle, then state IDLE, mem_out=0, info_ff=0.
